// File: rtl/alu_1bit.sv
// One bit slice of a ripple-carry ALU: combinational result/carry path plus
// a registered copy of Result and CarryOut with asynchronous clear.
module alu_1bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  input  logic       CIN,
  input  logic       AInvert,
  input  logic       BInvert,
  input  logic       Less,
  input  logic [2:0] Op,
  output logic       Result,
  output logic       CarryOut,
  output logic       Set,
  output logic       OvfLocal,
  output logic       Result_q,
  output logic       CarryOut_q
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_SLT  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_ADD  = 3'b100,
    OP_NOR  = 3'b101,
    OP_NAND = 3'b110,
    OP_XNOR = 3'b111
  } alu_op_e;

  logic a_eff;
  logic b_eff;
  logic sum_bit;

  assign a_eff   = A ^ AInvert;
  assign b_eff   = B ^ BInvert;
  assign sum_bit = a_eff ^ b_eff ^ CIN;

  // Carry is produced for every Op so the ripple chain stays valid for SLT/SUB.
  assign CarryOut = (a_eff & b_eff) | (a_eff & CIN) | (b_eff & CIN);
  assign Set      = sum_bit;
  assign OvfLocal = CIN ^ CarryOut;

  always_comb begin
    Result = 1'b0;
    case (alu_op_e'(Op))
      OP_AND:  Result = a_eff & b_eff;
      OP_SLT:  Result = Less;
      OP_OR:   Result = a_eff | b_eff;
      OP_XOR:  Result = a_eff ^ b_eff;
      OP_ADD:  Result = sum_bit;
      OP_NOR:  Result = ~(a_eff | b_eff);
      OP_NAND: Result = ~(a_eff & b_eff);
      OP_XNOR: Result = ~(a_eff ^ b_eff);
      default: Result = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Result_q   <= 1'b0;
      CarryOut_q <= 1'b0;
    end else begin
      Result_q   <= Result;
      CarryOut_q <= CarryOut;
    end
  end

endmodule

// File: tb/tb_alu_1bit.sv
// Self-checking bench for alu_1bit: arithmetic reference model compared every
// cycle, plus hand-computed directed vectors that pin the model.
module tb_alu_1bit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic       CIN = 1'b0;
  logic       AInvert = 1'b0;
  logic       BInvert = 1'b0;
  logic       Less = 1'b0;
  logic [2:0] Op = 3'b000;
  logic       Result;
  logic       CarryOut;
  logic       Set;
  logic       OvfLocal;
  logic       Result_q;
  logic       CarryOut_q;

  int checks = 0;
  int errors = 0;

  logic exp_result_q = 1'b0;
  logic exp_carry_q  = 1'b0;

  alu_1bit dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .CIN(CIN),
    .AInvert(AInvert), .BInvert(BInvert), .Less(Less), .Op(Op),
    .Result(Result), .CarryOut(CarryOut), .Set(Set), .OvfLocal(OvfLocal),
    .Result_q(Result_q), .CarryOut_q(CarryOut_q)
  );

  always #5 clk = ~clk;

  // Reference model: returns {result, carry, sum, ovf} using integer arithmetic.
  function automatic logic [3:0] model(input logic a_in, input logic b_in,
                                       input logic cin, input logic ai,
                                       input logic bi, input logic less,
                                       input logic [2:0] op);
    int a, b, total, res, carry, sum, ovf;
    a     = ai ? 1 - int'(a_in) : int'(a_in);
    b     = bi ? 1 - int'(b_in) : int'(b_in);
    total = a + b + int'(cin);
    sum   = total % 2;
    carry = (total >= 2) ? 1 : 0;
    case (op)
      3'd0:    res = a * b;
      3'd1:    res = int'(less);
      3'd2:    res = (a + b > 0) ? 1 : 0;
      3'd3:    res = (a + b == 1) ? 1 : 0;
      3'd4:    res = sum;
      3'd5:    res = (a + b == 0) ? 1 : 0;
      3'd6:    res = 1 - a * b;
      default: res = (a + b == 1) ? 0 : 1;
    endcase
    ovf = (carry != int'(cin)) ? 1 : 0;
    return {res[0], carry[0], sum[0], ovf[0]};
  endfunction

  task automatic check(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Registered expectation: cleared by reset, otherwise captures the model at the edge.
  always @(posedge clk or posedge reset) begin
    logic [3:0] m;
    if (reset) begin
      exp_result_q = 1'b0;
      exp_carry_q  = 1'b0;
    end else begin
      m = model(A, B, CIN, AInvert, BInvert, Less, Op);
      exp_result_q = m[3];
      exp_carry_q  = m[2];
    end
  end

  always @(negedge clk) begin
    logic [3:0] m;
    m = model(A, B, CIN, AInvert, BInvert, Less, Op);
    check("model_Result",     Result,     m[3]);
    check("model_CarryOut",   CarryOut,   m[2]);
    check("model_Set",        Set,        m[1]);
    check("model_OvfLocal",   OvfLocal,   m[0]);
    check("model_Result_q",   Result_q,   exp_result_q);
    check("model_CarryOut_q", CarryOut_q, exp_carry_q);
  end

  task automatic applyStimulus(input logic a_in, input logic b_in, input logic cin,
                               input logic ai, input logic bi, input logic less,
                               input logic [2:0] op);
    @(posedge clk);
    #2;
    A = a_in; B = b_in; CIN = cin; AInvert = ai; BInvert = bi; Less = less; Op = op;
  endtask

  task automatic checkOutput(input string name, input logic exp_res, input logic exp_cout);
    #1;
    check({name, "_Result"},   Result,   exp_res);
    check({name, "_CarryOut"}, CarryOut, exp_cout);
  endtask

  task automatic checkRegs(input string name, input logic exp_rq, input logic exp_cq);
    check({name, "_Result_q"},   Result_q,   exp_rq);
    check({name, "_CarryOut_q"}, CarryOut_q, exp_cq);
  endtask

  logic [2:0] sweep_ops [6] = '{3'b000, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
  logic       sweep_exp [6] = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0};

  initial begin
    $display("[TB] alu_1bit bench start");
    // Combinational path tracks inputs while registers are held in reset.
    A = 1'b1; B = 1'b1; Op = 3'b100;
    #1;
    checkOutput("during_reset", 1'b0, 1'b1);
    checkRegs("reset_state", 1'b0, 1'b0);
    @(posedge clk); @(posedge clk);
    #1;
    checkRegs("reset_held", 1'b0, 1'b0);
    #1;
    reset = 1'b0;

    applyStimulus(1, 1, 0, 0, 0, 0, 3'b100);
    checkOutput("add", 1'b0, 1'b1);
    check("add_Set", Set, 1'b0);
    check("add_OvfLocal", OvfLocal, 1'b1);
    @(posedge clk); #1;
    checkRegs("add_reg", 1'b0, 1'b1);

    applyStimulus(1, 0, 1, 0, 1, 0, 3'b100);
    checkOutput("sub", 1'b1, 1'b1);
    check("sub_OvfLocal", OvfLocal, 1'b0);
    @(posedge clk); #1;
    checkRegs("sub_reg", 1'b1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, sweep_ops[i]);
      checkOutput($sformatf("sweep_op%0d", sweep_ops[i]), sweep_exp[i], 1'b0);
    end

    applyStimulus(0, 0, 0, 1, 0, 0, 3'b000);
    checkOutput("ainv_and", 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 1, 0, 0, 3'b010);
    checkOutput("ainv_or", 1'b1, 1'b0);

    applyStimulus(1, 1, 0, 0, 0, 1, 3'b001);
    checkOutput("slt_less1", 1'b1, 1'b1);
    applyStimulus(1, 1, 0, 0, 0, 0, 3'b001);
    checkOutput("slt_less0", 1'b0, 1'b1);

    // Mid-cycle reset must clear the registers without a clock edge.
    applyStimulus(1, 1, 0, 0, 0, 0, 3'b010);
    checkOutput("pre_reset", 1'b1, 1'b1);
    @(posedge clk); #1;
    checkRegs("pre_reset_reg", 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkRegs("async_clear", 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkRegs("after_release_no_edge", 1'b0, 1'b0);
    @(posedge clk); #1;
    checkRegs("reload", 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    3'($urandom_range(0, 7)));
    end
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
